// File: rtl/score_bcd_scanner_pkg.sv
// Shared types and constants for the score BCD converter and 7-segment scanner.
package score_bcd_scanner_pkg;

  localparam int unsigned SCORE_W = 8;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD_W   = 3 * DIGIT_W;
  localparam int unsigned CONV_W  = BCD_W + SCORE_W;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 4;

  localparam logic [AN_W-1:0]  ANODE_OFF = 4'hF;
  localparam logic [SEG_W-1:0] SEG_OFF   = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} codes for decimal digits
  localparam logic [SEG_W-1:0] SEG_D0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_D1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_D2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_D3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_D4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_D5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_D6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_D7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_D8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_D9 = 7'h10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_L = 2'd1,
    CONV_R = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } digits_t;

  // Shift-add-3 correction applied to each BCD nibble before a shift
  function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Any hundreds value saturates the pair to 99
  function automatic digits_t to_digits(input logic [BCD_W-1:0] bcd);
    digits_t d;
    if (bcd[11:8] != 4'd0) d = '{tens: 4'd9, ones: 4'd9};
    else                   d = '{tens: bcd[7:4], ones: bcd[3:0]};
    return d;
  endfunction

endpackage

// File: rtl/score_seg_decode.sv
// Combinational digit to active-low 7-segment decode with blanking.
module score_seg_decode
  import score_bcd_scanner_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg7_c
);

  always_comb begin
    seg7_c = SEG_OFF;
    if (!blank) begin
      case (digit)
        4'd0:    seg7_c = SEG_D0;
        4'd1:    seg7_c = SEG_D1;
        4'd2:    seg7_c = SEG_D2;
        4'd3:    seg7_c = SEG_D3;
        4'd4:    seg7_c = SEG_D4;
        4'd5:    seg7_c = SEG_D5;
        4'd6:    seg7_c = SEG_D6;
        4'd7:    seg7_c = SEG_D7;
        4'd8:    seg7_c = SEG_D8;
        4'd9:    seg7_c = SEG_D9;
        default: seg7_c = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/score_bcd_scanner.sv
// Converts two binary scores to saturated BCD digit pairs and scans them
// onto a 4-digit multiplexed 7-segment display.
module score_bcd_scanner
  import score_bcd_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic               clk50,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score_l,
  input  logic [SCORE_W-1:0] score_r,
  input  logic               score_valid,
  output logic               busy,
  output logic [AN_W-1:0]    anode,
  output logic [SEG_W-1:0]   seg7
);

  localparam int unsigned           PRESC_W    = $clog2(SCAN_DIV);
  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [STEP_W-1:0]     STEP_LAST  = STEP_W'(SCORE_W - 1);

  state_t              state, state_nx;
  logic [CONV_W-1:0]   conv, conv_nx, conv_shift;
  logic [STEP_W-1:0]   step, step_nx;
  logic [SCORE_W-1:0]  cur_r, cur_r_nx, hold_l, hold_l_nx, hold_r, hold_r_nx;
  logic                pending, pending_nx;
  digits_t             res_l, res_l_nx;
  digits_t             disp_l, disp_l_nx, disp_r, disp_r_nx;

  logic [PRESC_W-1:0]  presc;
  logic [1:0]          idx;
  logic [DIGIT_W-1:0]  scan_digit;
  logic                scan_blank;
  logic [SEG_W-1:0]    seg_c;

  // One double-dabble step: correct every BCD nibble, then shift left
  always_comb begin
    conv_shift = {add3(conv[19:16]), add3(conv[15:12]), add3(conv[11:8]), conv[7:0]} << 1;
  end

  always_ff @(posedge clk50) begin
    if (!reset) begin
      state   <= IDLE;
      conv    <= '0;
      step    <= '0;
      cur_r   <= '0;
      hold_l  <= '0;
      hold_r  <= '0;
      pending <= 1'b0;
      res_l   <= '0;
      disp_l  <= '0;
      disp_r  <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      conv    <= conv_nx;
      step    <= step_nx;
      cur_r   <= cur_r_nx;
      hold_l  <= hold_l_nx;
      hold_r  <= hold_r_nx;
      pending <= pending_nx;
      res_l   <= res_l_nx;
      disp_l  <= disp_l_nx;
      disp_r  <= disp_r_nx;
      busy    <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx   = state;
    conv_nx    = conv;
    step_nx    = step;
    cur_r_nx   = cur_r;
    hold_l_nx  = hold_l;
    hold_r_nx  = hold_r;
    pending_nx = pending;
    res_l_nx   = res_l;
    disp_l_nx  = disp_l;
    disp_r_nx  = disp_r;

    // Requests arriving mid-conversion are held one deep, last one wins
    if (score_valid && (state == CONV_L || state == CONV_R)) begin
      hold_l_nx  = score_l;
      hold_r_nx  = score_r;
      pending_nx = 1'b1;
    end

    case (state)
      IDLE: begin
        if (score_valid) begin
          conv_nx  = CONV_W'(score_l);
          cur_r_nx = score_r;
          step_nx  = '0;
          state_nx = CONV_L;
        end
      end
      CONV_L: begin
        conv_nx = conv_shift;
        step_nx = step + STEP_W'(1);
        if (step == STEP_LAST) begin
          res_l_nx = to_digits(conv_shift[CONV_W-1 -: BCD_W]);
          conv_nx  = CONV_W'(cur_r);
          step_nx  = '0;
          state_nx = CONV_R;
        end
      end
      CONV_R: begin
        conv_nx = conv_shift;
        step_nx = step + STEP_W'(1);
        if (step == STEP_LAST) state_nx = COMMIT;
      end
      COMMIT: begin
        disp_l_nx = res_l;
        disp_r_nx = to_digits(conv[CONV_W-1 -: BCD_W]);
        step_nx   = '0;
        // A request in this cycle supersedes any held one
        if (score_valid) begin
          conv_nx    = CONV_W'(score_l);
          cur_r_nx   = score_r;
          pending_nx = 1'b0;
          state_nx   = CONV_L;
        end else if (pending) begin
          conv_nx    = CONV_W'(hold_l);
          cur_r_nx   = hold_r;
          pending_nx = 1'b0;
          state_nx   = CONV_L;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Slot order: right ones, right tens, left ones, left tens
  always_comb begin
    case (idx)
      2'd0:    scan_digit = disp_r.ones;
      2'd1:    scan_digit = disp_r.tens;
      2'd2:    scan_digit = disp_l.ones;
      default: scan_digit = disp_l.tens;
    endcase
    scan_blank = BLANK_LZ && idx[0] && (scan_digit == 4'd0);
  end

  score_seg_decode u_seg_decode (
    .digit  (scan_digit),
    .blank  (scan_blank),
    .seg7_c (seg_c)
  );

  always_ff @(posedge clk50) begin
    if (!reset) begin
      presc <= '0;
      idx   <= 2'd0;
      anode <= ANODE_OFF;
      seg7  <= SEG_OFF;
    end else begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + PRESC_W'(1);
      end
      anode <= ~(4'd1 << idx);
      seg7  <= seg_c;
    end
  end

endmodule

// File: tb/tb_score_bcd_scanner.sv
// Scoreboard bench: stimulus queues expected results, a monitor checks each
// completed conversion (busy length and all four scanned digits).
module tb_score_bcd_scanner;
  import score_bcd_scanner_pkg::*;

  localparam int unsigned SCAN_DIV = 4;

  logic       clk50 = 1'b0;
  logic       reset;
  logic [7:0] score_l, score_r;
  logic       score_valid;
  logic       busy;
  logic [3:0] anode;
  logic [6:0] seg7;

  always #5 clk50 = ~clk50;

  score_bcd_scanner #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
    .clk50       (clk50),
    .reset       (reset),
    .score_l     (score_l),
    .score_r     (score_r),
    .score_valid (score_valid),
    .busy        (busy),
    .anode       (anode),
    .seg7        (seg7)
  );

  typedef struct packed {
    logic [7:0]      busy_len;
    logic [3:0][6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   mon_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int len, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    exp_t e;
    e.busy_len = 8'(len);
    e.seg      = {s3, s2, s1, s0};
    return e;
  endfunction

  task automatic send(input logic [7:0] l, input logic [7:0] r);
    @(posedge clk50); #1;
    score_l = l; score_r = r; score_valid = 1'b1;
    @(posedge clk50); #1;
    score_valid = 1'b0;
  endtask

  // Pulse score_valid so it is sampled k edges after the previous sampled edge
  task automatic pulse_after(input int k, input logic [7:0] l, input logic [7:0] r);
    repeat (k - 1) @(posedge clk50);
    #1;
    score_l = l; score_r = r; score_valid = 1'b1;
    @(posedge clk50); #1;
    score_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (mon_done < target && t < 400) begin
      @(posedge clk50);
      t++;
    end
    if (mon_done < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_result: monitor count %0d expected %0d", mon_done, target);
    end
  endtask

  // Monitor: measure each busy window, then collect one full scan of digits
  initial begin : monitor
    exp_t            e;
    int              len;
    logic [3:0][6:0] got;
    logic [3:0]      seen;
    logic            onehot_ok;
    forever begin
      @(negedge clk50);
      if (busy === 1'b1) begin
        len = 0;
        while (busy === 1'b1 && len < 200) begin
          len++;
          @(negedge clk50);
        end
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: busy window of %0d cycles with empty queue", len);
        end else begin
          e = exp_q.pop_front();
          check("busy_len", 32'(len), 32'(e.busy_len));
          got = '0;
          seen = '0;
          onehot_ok = 1'b1;
          repeat (24) begin
            @(negedge clk50);
            if (anode !== ANODE_OFF) begin
              if ($countones(~anode) != 1) onehot_ok = 1'b0;
              for (int i = 0; i < 4; i++) begin
                if (anode[i] === 1'b0) begin
                  got[i]  = seg7;
                  seen[i] = 1'b1;
                end
              end
            end
          end
          check("anode_onehot", 32'(onehot_ok), 32'd1);
          for (int i = 0; i < 4; i++) begin
            check($sformatf("slot%0d_seen", i), 32'(seen[i]), 32'd1);
            check($sformatf("slot%0d_seg", i), 32'(got[i]), 32'(e.seg[i]));
          end
        end
        mon_done++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [3:0] aseq [5];
    aseq = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    reset = 1'b0;
    score_valid = 1'b0;
    score_l = '0;
    score_r = '0;

    repeat (3) @(posedge clk50);
    @(negedge clk50);
    check("rst_anode", 32'(anode), 32'h0F);
    check("rst_seg7", 32'(seg7), 32'h7F);
    check("rst_busy", 32'(busy), 32'd0);

    // Scan order and hold time after reset release, all digits zero
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk50);
      check("scan_anode", 32'(anode), 32'(aseq[k / 4]));
      if (k < 4)      check("slot0_zero", 32'(seg7), 32'h40);
      else if (k < 8) check("slot1_blank", 32'(seg7), 32'h7F);
    end

    exp_q.push_back(mk(17, 7'h19, 7'h24, 7'h7F, 7'h78));
    send(8'd42, 8'd7);
    wait_done(1);

    exp_q.push_back(mk(17, 7'h10, 7'h10, 7'h10, 7'h10));
    send(8'd150, 8'd99);
    wait_done(2);

    exp_q.push_back(mk(17, 7'h7F, 7'h40, 7'h7F, 7'h40));
    send(8'd0, 8'd0);
    wait_done(3);

    exp_q.push_back(mk(17, 7'h10, 7'h10, 7'h10, 7'h10));
    send(8'd255, 8'd100);
    wait_done(4);

    exp_q.push_back(mk(17, 7'h7F, 7'h12, 7'h02, 7'h40));
    send(8'd5, 8'd60);
    wait_done(5);

    // Two requests during busy: only the last is converted, back to back
    exp_q.push_back(mk(34, 7'h79, 7'h24, 7'h79, 7'h30));
    send(8'd88, 8'd61);
    pulse_after(4, 8'd5, 8'd6);
    pulse_after(6, 8'd12, 8'd13);
    wait_done(6);

    // Request in the commit cycle chains straight into a new conversion
    exp_q.push_back(mk(34, 7'h7F, 7'h30, 7'h7F, 7'h19));
    send(8'd20, 8'd19);
    pulse_after(17, 8'd3, 8'd4);
    wait_done(7);

    // Reset mid-conversion aborts and clears the displayed digits
    exp_q.push_back(mk(9, 7'h7F, 7'h40, 7'h7F, 7'h40));
    send(8'd77, 8'd77);
    repeat (8) @(posedge clk50);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk50);
    #1 reset = 1'b1;
    wait_done(8);

    exp_q.push_back(mk(17, 7'h19, 7'h24, 7'h7F, 7'h78));
    send(8'd42, 8'd7);
    wait_done(9);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
